// File: rtl/matrix_loader_pkg.sv
// Shared definitions for the matrix loader and its coprocessor neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package matrix_loader_pkg;

    localparam int ADDR_W      = 7;    // 128-entry MemoryBlock
    localparam int DATA_W      = 16;   // {B element, A element}
    localparam int ELEM_W      = 8;
    localparam int OP_W        = 3;
    localparam int N_ELEMS_DEF = 25;   // 5x5 matrix, row-major

    typedef enum logic [2:0] {
        IDLE,
        HDR_OP,
        HDR_SCALAR,
        LOAD_A,
        LOAD_B,
        DONE
    } ld_state_t;

    // Element address; wraps modulo 2**ADDR_W by construction of the width.
    function automatic logic [ADDR_W-1:0] elem_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] idx
    );
        return base + idx;
    endfunction

endpackage

// File: rtl/matrix_loader.sv
// Streams a header (op, scalar) then matrices A and B into memory as {B,A} words.
// Latency: one memory write per B byte, issued the cycle after that byte transfers.
// Backpressure: in_ready high in HDR_OP/HDR_SCALAR/LOAD_A/LOAD_B, low in IDLE/DONE.
//
// Ports: clk, rst (sync, active-high); start request; in_valid/in_ready/in_data
// byte stream; mem_we/mem_addr/mem_data memory write port; op_code/scalar
// latched header for the coprocessor; busy (not IDLE); done (one-cycle pulse).
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 7'd0,
    parameter int                N_ELEMS   = N_ELEMS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [OP_W-1:0]   op_code,
    output logic [ELEM_W-1:0] scalar,
    output logic              busy,
    output logic              done
);

    localparam int               IDX_W    = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

    ld_state_t         state;
    logic [IDX_W-1:0]  index;
    logic [ELEM_W-1:0] a_buf [N_ELEMS];
    logic              xfer;

    // Handshake and status are pure decodes of the state register.
    assign in_ready = (state == HDR_OP) || (state == HDR_SCALAR) ||
                      (state == LOAD_A) || (state == LOAD_B);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            index    <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            op_code  <= '0;
            scalar   <= '0;
        end else begin
            // Write strobe is a single-cycle pulse per B transfer; address and
            // data simply hold between writes.
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) state <= HDR_OP;
                end
                HDR_OP: begin
                    if (xfer) begin
                        op_code <= in_data[OP_W-1:0];
                        state   <= HDR_SCALAR;
                    end
                end
                HDR_SCALAR: begin
                    if (xfer) begin
                        scalar <= in_data;
                        index  <= '0;
                        state  <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (xfer) begin
                        if (index == LAST_IDX) begin
                            index <= '0;
                            state <= LOAD_B;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        mem_we   <= 1'b1;
                        mem_addr <= elem_addr(BASE_ADDR, ADDR_W'(index));
                        mem_data <= {in_data, a_buf[index]};
                        if (index == LAST_IDX) begin
                            index <= '0;
                            state <= DONE;   // last write lands in this DONE cycle
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A-matrix staging buffer; contents are don't-care after reset because
    // every load rewrites all entries before LOAD_B reads them.
    always_ff @(posedge clk) begin
        if (!rst && (state == LOAD_A) && xfer) begin
            a_buf[index] <= in_data;
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: two instances (base 0 and base 120) share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_matrix_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;

    logic        in_ready0, mem_we0, busy0, done0;
    logic [6:0]  mem_addr0;
    logic [15:0] mem_data0;
    logic [2:0]  op_code0;
    logic [7:0]  scalar0;

    logic        in_ready1, mem_we1, busy1, done1;
    logic [6:0]  mem_addr1;
    logic [15:0] mem_data1;
    logic [2:0]  op_code1;
    logic [7:0]  scalar1;

    always #5 clk = ~clk;

    matrix_loader #(.BASE_ADDR(7'd0), .N_ELEMS(25)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_data(mem_data0),
        .op_code(op_code0), .scalar(scalar0), .busy(busy0), .done(done0)
    );

    matrix_loader #(.BASE_ADDR(7'd120), .N_ELEMS(25)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .op_code(op_code1), .scalar(scalar1), .busy(busy1), .done(done1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference memories and write/done bookkeeping, filled from the write ports.
    logic [15:0] mem0 [128];
    logic [15:0] mem1 [128];
    int wr0, wr1, addr_err0, addr_err1;
    int done_cnt0, done_cnt1, done_we0, wr_at_done0;
    int we_err, gap_err, rdy_err;
    bit toggle;

    logic [7:0] a_vec [25];
    logic [7:0] b_vec [25];

    initial begin
        forever begin
            @(negedge clk);
            if (mem_we0 === 1'b1) begin
                if (mem_addr0 !== 7'(wr0)) addr_err0++;
                mem0[mem_addr0] = mem_data0;
                wr0++;
            end
            if (mem_we1 === 1'b1) begin
                if (mem_addr1 !== 7'(120 + wr1)) addr_err1++;
                mem1[mem_addr1] = mem_data1;
                wr1++;
            end
            if (done0 === 1'b1) begin
                done_cnt0++;
                if (mem_we0 === 1'b1) done_we0++;
                wr_at_done0 = wr0;
            end
            if (done1 === 1'b1) done_cnt1++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 128; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        wr0 = 0; wr1 = 0; addr_err0 = 0; addr_err1 = 0;
        done_cnt0 = 0; done_cnt1 = 0; done_we0 = 0; wr_at_done0 = 0;
        we_err = 0; gap_err = 0; rdy_err = 0;
    endtask

    // One byte transfer; the write strobe must follow B bytes only, and a
    // gap cycle (toggle mode) must never produce a write.
    task automatic send(input logic [7:0] b, input bit is_b);
        if (in_ready0 !== 1'b1) rdy_err++;
        in_valid = 1'b1;
        in_data  = b;
        tick();
        if (mem_we0 !== is_b) we_err++;
        if (toggle) begin
            in_valid = 1'b0;
            tick();
            if (mem_we0 !== 1'b0) gap_err++;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic stream_hdr(input logic [7:0] op, input logic [7:0] sc);
        send(op, 1'b0);
        send(sc, 1'b0);
    endtask

    task automatic stream_a(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(a_vec[i], 1'b0);
    endtask

    task automatic stream_b(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(b_vec[i], 1'b1);
        in_valid = 1'b0;
    endtask

    function automatic int data_errs();
        int e = 0;
        for (int k = 0; k < 25; k++) begin
            if (mem0[k] !== {b_vec[k], a_vec[k]}) e++;
            if (mem1[7'(120 + k)] !== {b_vec[k], a_vec[k]}) e++;
        end
        return e;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; toggle = 1'b0;
        clear_models();

        // Reset state
        tick(); tick();
        check("rst_in_ready", in_ready0, 0);
        check("rst_busy",     busy0,     0);
        check("rst_done",     done0,     0);
        check("rst_mem_we",   mem_we0,   0);
        check("rst_mem_addr", mem_addr0, 0);
        check("rst_mem_data", mem_data0, 0);
        check("rst_op_code",  op_code0,  0);
        check("rst_scalar",   scalar0,   0);
        check("rst_addr_b120", mem_addr1, 0);
        rst = 1'b0;
        tick();

        // Continuous stream: op 1, scalar 3, A = 1..25, B = 1
        for (int k = 0; k < 25; k++) begin
            a_vec[k] = 8'(k + 1);
            b_vec[k] = 8'h01;
        end
        clear_models();
        do_start();
        check("start_busy",     busy0,     1);
        check("start_in_ready", in_ready0, 1);
        stream_hdr(8'h01, 8'h03);
        stream_a(0, 24);
        check("load_a_no_write", wr0, 0);
        stream_b(0, 24);
        tick(); tick();
        check("t1_op_code",    op_code0,    1);
        check("t1_scalar",     scalar0,     8'h03);
        check("t1_writes",     wr0,         25);
        check("t1_addr_seq",   addr_err0,   0);
        check("t1_word0",      mem0[0],     16'h0101);
        check("t1_word24",     mem0[24],    16'h0119);
        check("t1_data",       data_errs(), 0);
        check("t1_done_cnt",   done_cnt0,   1);
        check("t1_done_w_we",  done_we0,    1);
        check("t1_wr_at_done", wr_at_done0, 25);
        check("t1_we_timing",  we_err,      0);
        check("t1_rdy",        rdy_err,     0);
        check("t1_busy_after", busy0,       0);
        // Base 120 instance wraps after address 127
        check("wrap_writes",   wr1,         25);
        check("wrap_addr_seq", addr_err1,   0);
        check("wrap_word120",  mem1[120],   16'h0101);
        check("wrap_word127",  mem1[127],   16'h0108);
        check("wrap_word0",    mem1[0],     16'h0109);
        check("wrap_word16",   mem1[16],    16'h0119);
        check("wrap_done_cnt", done_cnt1,   1);

        // Same stream with in_valid toggling every cycle
        clear_models();
        toggle = 1'b1;
        do_start();
        stream_hdr(8'h01, 8'h03);
        stream_a(0, 24);
        stream_b(0, 24);
        toggle = 1'b0;
        tick(); tick();
        check("t2_writes",   wr0,         25);
        check("t2_data",     data_errs(), 0);
        check("t2_gap_we",   gap_err,     0);
        check("t2_we_timing", we_err,     0);
        check("t2_rdy",      rdy_err,     0);
        check("t2_done_cnt", done_cnt0,   1);

        // Reset after the 10th B byte, with start and a transfer in the same cycle
        for (int k = 0; k < 25; k++) begin
            a_vec[k] = 8'(8'h40 + k);
            b_vec[k] = 8'(8'hC0 + k);
        end
        clear_models();
        do_start();
        stream_hdr(8'h06, 8'h55);
        stream_a(0, 24);
        stream_b(0, 9);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = b_vec[10];
        tick();
        check("mid_rst_we",       mem_we0,   0);
        check("mid_rst_busy",     busy0,     0);
        check("mid_rst_in_ready", in_ready0, 0);
        check("mid_rst_op_code",  op_code0,  0);
        check("mid_rst_mem_addr", mem_addr0, 0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick(); tick();
        check("mid_rst_writes",  wr0,       10);
        check("mid_rst_idle",    busy0,     0);
        check("mid_rst_no_done", done_cnt0, 0);
        clear_models();
        do_start();
        stream_hdr(8'h06, 8'h55);
        stream_a(0, 24);
        stream_b(0, 24);
        tick(); tick();
        check("reload_op_code", op_code0,    6);
        check("reload_scalar",  scalar0,     8'h55);
        check("reload_writes",  wr0,         25);
        check("reload_data",    data_errs(), 0);
        check("reload_word9",   mem0[9],     16'hC949);

        // in_valid in IDLE without start, then start pulsed during LOAD_A
        clear_models();
        in_valid = 1'b1; in_data = 8'h07;
        tick(); tick(); tick();
        check("idle_busy",     busy0,     0);
        check("idle_in_ready", in_ready0, 0);
        check("idle_op_hold",  op_code0,  6);
        check("idle_scalar",   scalar0,   8'h55);
        in_valid = 1'b0;
        for (int k = 0; k < 25; k++) begin
            a_vec[k] = 8'(8'hF0 - k);
            b_vec[k] = 8'(3 * k);
        end
        do_start();
        stream_hdr(8'h02, 8'h09);
        stream_a(0, 4);
        start = 1'b1;
        stream_a(5, 5);
        start = 1'b0;
        check("ign_start_busy",  busy0,     1);
        check("ign_start_rdy",   in_ready0, 1);
        check("ign_start_op",    op_code0,  2);
        stream_a(6, 24);
        stream_b(0, 24);
        tick(); tick();
        check("ign_start_writes", wr0,         25);
        check("ign_start_data",   data_errs(), 0);
        check("ign_start_done",   done_cnt0,   1);

        // Upper header bits ignored; extreme signed elements
        for (int k = 0; k < 25; k++) begin
            a_vec[k] = (k % 2 == 0) ? 8'h80 : 8'h7F;
            b_vec[k] = (k % 2 == 0) ? 8'h7F : 8'h80;
        end
        clear_models();
        do_start();
        stream_hdr(8'hFA, 8'h80);
        stream_a(0, 24);
        stream_b(0, 24);
        tick(); tick();
        check("sgn_op_code", op_code0,    3'b010);
        check("sgn_scalar",  scalar0,     8'h80);
        check("sgn_word0",   mem0[0],     16'h7F80);
        check("sgn_word1",   mem0[1],     16'h807F);
        check("sgn_data",    data_errs(), 0);
        check("sgn_mem_hold", mem_data0,  16'h7F80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
